niosii_system_input_pio_irq: RTL



---
 rtl/niosii_system_input_pio_irq_pkg.sv | 24 ++
 rtl/niosii_system_input_pio_irq_if.sv | 22 ++
 rtl/niosii_system_input_pio_irq_debounce.sv | 88 ++++++++
 rtl/niosii_system_input_pio_irq.sv | 110 +++++++++++
 4 files changed

// File: rtl/niosii_system_input_pio_irq_pkg.sv
// Shared definitions for the input PIO: register offsets, edge selection
// codes, debounce state encoding and a counter sizing helper.
package niosII_pio_pkg;

    typedef logic [1:0] pio_addr_t;

    localparam pio_addr_t ADDR_DATA    = 2'd0;
    localparam pio_addr_t ADDR_RSVD    = 2'd1;
    localparam pio_addr_t ADDR_IRQMASK = 2'd2;
    localparam pio_addr_t ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    // Width of a counter that must hold 0..cycles; never narrower than 1 bit.
    function automatic int cntWidth(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/niosii_system_input_pio_irq_if.sv
// Avalon-MM slave bus of the input PIO, including its interrupt line.
interface niosii_system_input_pio_irq_if;
    import niosII_pio_pkg::*;

    pio_addr_t   address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/niosii_system_input_pio_irq_debounce.sv
// One input channel: metastability synchroniser followed by a debouncer
// that only accepts a new level after it has been stable long enough.
module niosII_pio_debounce_bit
    import niosII_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    output logic o_deb
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            logic r_deb;

            // No filtering: the debounced value simply follows the synchroniser.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_deb <= 1'b0;
                end else begin
                    r_deb <= w_sync;
                end
            end

            assign o_deb = r_deb;
        end else begin : g_fsm
            localparam int              CNT_W    = cntWidth(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
            localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

            logic [0:0]       r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             r_deb;

            // Count consecutive cycles where the synchronised input disagrees
            // with the accepted level; any return to the old level restarts it.
            // A single required cycle is accepted straight from STABLE because
            // the counter would otherwise start past its terminal value.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                    r_deb   <= 1'b0;
                end else if (r_state == ST_STABLE) begin
                    if (w_sync != r_deb) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_deb <= w_sync;
                        end else begin
                            r_state <= ST_COUNTING;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end else begin
                    if (w_sync == r_deb) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt >= CNT_LAST) begin
                        r_deb   <= w_sync;
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
            end

            assign o_deb = r_deb;
        end
    endgenerate

endmodule

// File: rtl/niosii_system_input_pio_irq.sv
// Avalon-MM input PIO with per-bit debouncing, edge capture, interrupt
// mask and a level-sensitive interrupt request.
module niosii_system_input_pio_irq
    import niosII_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [WIDTH-1:0]            in_port,
    niosii_system_input_pio_irq_if.slave bus
);

    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] r_deb_d;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic             w_wr;
    logic [31:0]      w_rdmux;
    logic [31:0]      r_readdata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            niosII_pio_debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_bit (
                .clk     (clk),
                .reset_n (reset_n),
                .i_in    (in_port[i]),
                .o_deb   (w_deb[i])
            );
        end
    endgenerate

    assign w_wr   = bus.chipselect & ~bus.write_n;
    assign w_rise = w_deb & ~r_deb_d;
    assign w_fall = ~w_deb & r_deb_d;

    // Pick which debounced transitions count as events.
    always_comb begin
        w_event = w_rise;
        case (EDGE_TYPE)
            EDGE_FALLING: w_event = w_fall;
            EDGE_ANY:     w_event = w_rise | w_fall;
            default:      w_event = w_rise;
        endcase
    end

    // Remember last cycle's debounced value for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_d <= '0;
        end else begin
            r_deb_d <= w_deb;
        end
    end

    // Interrupt mask register; only the implemented bits are stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
        end else if (w_wr && (bus.address == ADDR_IRQMASK)) begin
            r_irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    assign w_clear = (w_wr && (bus.address == ADDR_EDGECAP)) ? bus.writedata[WIDTH-1:0]
                                                             : '0;

    // Sticky edge capture: a fresh event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clear) | w_event;
        end
    end

    // Select the addressed register, zero-extended; unused offsets read 0.
    always_comb begin
        w_rdmux = '0;
        case (bus.address)
            ADDR_DATA:    w_rdmux[WIDTH-1:0] = w_deb;
            ADDR_IRQMASK: w_rdmux[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: w_rdmux[WIDTH-1:0] = r_edgecap;
            default:      w_rdmux = '0;
        endcase
    end

    // Register read data every cycle, independent of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdmux;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = |(r_edgecap & r_irqmask);

endmodule
